// File: rtl/logs_pwm_demod.sv
// logs_pwm_demod: recovers multi-bit amplitude samples from a 1-bit PWM stream
// by counting high cycles over a free-running window of WIN clocks. Each window
// result is offered through a one-entry valid/ready buffer; a result that
// arrives while the buffer is still full is dropped and flagged by a sticky
// overrun bit.
//
// Optional feature (macro LOGS_PWM_AVG_EN): deliver the round-half-up average
// of the current and previous window instead of the raw count. The first window
// after reset or after en=0 delivers the raw count.
//
// Ports:
//   clk           clock
//   reset         asynchronous reset, active-high
//   en            demodulator enable; low discards the partial window
//   pwm_in        PWM audio stream (asynchronous to clk)
//   sample        high-cycle count of the last window, 0..WIN
//   sample_valid  sample holds unconsumed data
//   sample_ready  consumer accepts sample on this edge when valid is high
//   overrun       sticky: a window result was dropped
//   overrun_clr   synchronous clear of overrun
module logs_pwm_demod #(
  parameter int unsigned WIN         = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       pwm_in,
  output logic [$clog2(WIN+1)-1:0]   sample,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int unsigned SW = $clog2(WIN + 1);
  localparam int unsigned CW = $clog2(WIN);
  localparam int unsigned AW = SW + 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);

  logic          pwm_s;
  logic [CW-1:0] win_cnt;
  logic [SW-1:0] hi_cnt;
  logic          done_c;
  logic [SW-1:0] result_c;
  logic [SW-1:0] deliver_c;

  // Input synchronizer; SYNC_STAGES=0 feeds pwm_in straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign pwm_s = pwm_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= pwm_in;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign pwm_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // The WIN-th counted cycle closes the window; its own bit is folded in here.
  assign done_c   = en && (win_cnt == WIN_LAST);
  assign result_c = hi_cnt + SW'(pwm_s);

`ifdef LOGS_PWM_AVG_EN
  logic [SW-1:0] prev;
  logic          first;
  logic [AW-1:0] avg_sum_c;

  assign avg_sum_c = AW'(result_c) + AW'(prev) + AW'(1);
  assign deliver_c = first ? result_c : avg_sum_c[AW-1:1];

  // History tracks every completed window, including ones the buffer drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= '0;
      first <= 1'b1;
    end else if (!en) begin
      first <= 1'b1;
    end else if (done_c) begin
      prev  <= result_c;
      first <= 1'b0;
    end
  end
`else
  assign deliver_c = result_c;
`endif

  // Window and high-cycle counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
    end else if (!en || done_c) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      win_cnt <= win_cnt + CW'(1);
      hi_cnt  <= hi_cnt + SW'(pwm_s);
    end
  end

  // One-entry output buffer; a new result may replace data consumed this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (done_c && (!sample_valid || sample_ready)) begin
      sample       <= deliver_c;
      sample_valid <= 1'b1;
    end else if (!done_c && sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun; a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (done_c && sample_valid && !sample_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logs_pwm_demod.sv
// Bench for logs_pwm_demod: randomized and directed stimulus checked against a
// window-of-bits reference model plus fixed expected values.
module tb_logs_pwm_demod;

  localparam int unsigned WIN  = 256;
  localparam int unsigned SYNC = 2;
  localparam int unsigned SW   = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          pwm_in = 1'b0;
  logic          sample_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  logs_pwm_demod #(.WIN(WIN), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  // Reference model: delay line of input bits, list of bits in the open window.
  int            sync_q[$];
  int            win_bits[$];
  logic [SW-1:0] m_sample = '0;
  logic          m_valid = 1'b0;
  logic          m_ovr = 1'b0;
  int            m_prev = 0;
  bit            m_first = 1'b1;
  int            m_dones = 0;

  always @(posedge clk or posedge reset) begin : model
    int  ps;
    int  res;
    int  dv;
    bit  done;
    bit  set_ovr;
    if (reset) begin
      sync_q.delete();
      for (int i = 0; i < int'(SYNC); i++) sync_q.push_back(0);
      win_bits.delete();
      m_sample = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_prev   = 0;
      m_first  = 1'b1;
    end else begin
      ps = sync_q.pop_front();
      sync_q.push_back(int'(pwm_in));
      done = 1'b0;
      res  = 0;
      if (!en) begin
        win_bits.delete();
        m_first = 1'b1;
      end else begin
        win_bits.push_back(ps);
        if (win_bits.size() == int'(WIN)) begin
          res = win_bits.sum();
          win_bits.delete();
          done = 1'b1;
        end
      end
      set_ovr = done && m_valid && !sample_ready;
      if (done) begin
`ifdef LOGS_PWM_AVG_EN
        dv = m_first ? res : (res + m_prev + 1) / 2;
        m_prev  = res;
        m_first = 1'b0;
`else
        dv = res;
`endif
        m_dones++;
        if (!m_valid || sample_ready) begin
          m_sample = SW'(dv);
          m_valid  = 1'b1;
        end
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (sample !== '0) begin bad++; $display("FAIL reset_sample: got %0d want 0", sample); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ones();
    int n;
    en = 1'b0; pwm_in = 1'b1; sample_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      n = 0;
      do begin
        tick(); n++;
        total++;
        if ({sample_valid, overrun, sample} !== {m_valid, m_ovr, m_sample}) begin
          bad++;
          $display("FAIL ones_cycle: got v=%b o=%b s=%0d want v=%b o=%b s=%0d",
                   sample_valid, overrun, sample, m_valid, m_ovr, m_sample);
        end
      end while (!sample_valid && n < 400);
      total++; if (n !== int'(WIN)) begin bad++; $display("FAIL ones_latency: got %0d want %0d", n, WIN); end
      total++; if (sample !== SW'(WIN)) begin bad++; $display("FAIL ones_value: got %0d want %0d", sample, WIN); end
    end
  endtask

  task automatic test_pattern(input int period, input int highs, input int expect_val);
    int seen;
    seen = 0;
    en = 1'b1; sample_ready = 1'b1; overrun_clr = 1'b0;
    for (int c = 0; c < 3 * int'(WIN) + 8; c++) begin
      pwm_in = ((c % period) < highs);
      tick();
      total++;
      if ({sample_valid, overrun, sample} !== {m_valid, m_ovr, m_sample}) begin
        bad++;
        $display("FAIL pattern_cycle p=%0d h=%0d: got v=%b o=%b s=%0d want v=%b o=%b s=%0d",
                 period, highs, sample_valid, overrun, sample, m_valid, m_ovr, m_sample);
      end
      if (sample_valid) begin
        seen++;
        if (seen > 1) begin
          total++;
          if (sample !== SW'(expect_val)) begin
            bad++;
            $display("FAIL pattern_value p=%0d h=%0d: got %0d want %0d", period, highs, sample, expect_val);
          end
        end
      end
    end
    total++; if (seen < 3) begin bad++; $display("FAIL pattern_count p=%0d: got %0d windows want >=3", period, seen); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL pattern_overrun p=%0d: got %b want 0", period, overrun); end
  endtask

  task automatic test_overrun();
    logic [SW-1:0] held;
    int n;
    int d;
    en = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
    n = 0;
    while (!m_valid && n < 600) begin
      pwm_in = $urandom_range(0, 1); tick(); n++;
      total++;
      if ({sample_valid, overrun, sample} !== {m_valid, m_ovr, m_sample}) begin
        bad++;
        $display("FAIL ovr_fill: got v=%b o=%b s=%0d want v=%b o=%b s=%0d",
                 sample_valid, overrun, sample, m_valid, m_ovr, m_sample);
      end
    end
    held = m_sample;
    n = 0;
    while (!m_ovr && n < 600) begin
      pwm_in = $urandom_range(0, 1); tick(); n++;
      total++;
      if ({sample_valid, overrun, sample} !== {m_valid, m_ovr, m_sample}) begin
        bad++;
        $display("FAIL ovr_hold: got v=%b o=%b s=%0d want v=%b o=%b s=%0d",
                 sample_valid, overrun, sample, m_valid, m_ovr, m_sample);
      end
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", sample_valid); end
    total++; if (sample !== held) begin bad++; $display("FAIL ovr_held: got %0d want %0d", sample, held); end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    // Clear held high across a dropping window end: the set must win.
    overrun_clr = 1'b1;
    d = m_dones; n = 0;
    while (m_dones == d && n < 600) begin pwm_in = $urandom_range(0, 1); tick(); n++; end
    overrun_clr = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    total++; if (sample !== held) begin bad++; $display("FAIL ovr_held2: got %0d want %0d", sample, held); end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear2: got %b want 0", overrun); end
    sample_ready = 1'b1; tick();
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", sample_valid); end
  endtask

  task automatic test_en_drop();
    int d;
    int n;
    en = 1'b1; sample_ready = 1'b1; overrun_clr = 1'b0;
    d = m_dones; n = 0;
    while (m_dones == d && n < 600) begin pwm_in = $urandom_range(0, 1); tick(); n++; end
    repeat (100) begin pwm_in = $urandom_range(0, 1); tick(); end
    en = 1'b0;
    repeat (5) begin
      pwm_in = $urandom_range(0, 1); tick();
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL endrop_idle: got %b want 0", sample_valid); end
    end
    en = 1'b1; n = 0;
    do begin
      pwm_in = $urandom_range(0, 1); tick(); n++;
    end while (!sample_valid && n < 400);
    total++; if (n !== int'(WIN)) begin bad++; $display("FAIL endrop_latency: got %0d want %0d", n, WIN); end
    total++; if (sample !== m_sample) begin bad++; $display("FAIL endrop_value: got %0d want %0d", sample, m_sample); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
    repeat (300) begin pwm_in = 1'b1; tick(); end
    total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %b want 1", sample_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (sample !== '0) begin bad++; $display("FAIL rstmid_sample: got %0d want 0", sample); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", sample_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      pwm_in       = $urandom_range(0, 1);
      en           = ($urandom_range(0, 999) != 0);
      sample_ready = ($urandom_range(0, 9) < 3);
      overrun_clr  = ($urandom_range(0, 49) == 0);
      tick();
      total++;
      if ({sample_valid, overrun, sample} !== {m_valid, m_ovr, m_sample}) begin
        bad++;
        $display("FAIL random_cycle %0d: got v=%b o=%b s=%0d want v=%b o=%b s=%0d",
                 c, sample_valid, overrun, sample, m_valid, m_ovr, m_sample);
      end
    end
    overrun_clr = 1'b0;
  endtask

  task automatic test_avg();
    int got[$];
    int want1;
    en = 1'b0; pwm_in = 1'b1; sample_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    for (int i = 0; i < 2 * int'(WIN) + 4; i++) begin
      if (i == int'(WIN) - 2) pwm_in = 1'b0;
      tick();
      if (sample_valid) got.push_back(int'(sample));
    end
`ifdef LOGS_PWM_AVG_EN
    want1 = int'(WIN) / 2;
`else
    want1 = 0;
`endif
    total++; if (got.size() != 2) begin bad++; $display("FAIL avg_count: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      total++; if (got[0] != int'(WIN)) begin bad++; $display("FAIL avg_first: got %0d want %0d", got[0], WIN); end
      total++; if (got[1] != want1) begin bad++; $display("FAIL avg_second: got %0d want %0d", got[1], want1); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_pattern(1, 0, 0);
    test_pattern(4, 1, 64);
    test_pattern(8, 5, 160);
    test_overrun();
    test_en_drop();
    test_reset_mid();
    test_random();
    test_avg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logs_pwm_demod.md
Name: logs_pwm_demod

Overview:
- Recovers multi-bit amplitude samples from a 1-bit PWM audio stream, such as the output of the square-wave sonifier's mixer.
- Counts high cycles over a fixed, free-running window of WIN clocks and presents each count as a sample.
- Output uses a valid/ready handshake into a one-entry buffer, with a sticky overrun flag.
- Used on-chip for loopback self-test and as a level monitor of the generated audio.

Parameters:
- WIN, 256: window length in clk cycles; must be >= 2.
- SYNC_STAGES, 2: synchronizer flops on pwm_in; 0 bypasses the synchronizer.
- SW (localparam): $clog2(WIN+1), the sample width. 9 at default WIN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-high
- en  input  1  demodulator enable; low discards the partial window
- pwm_in  input  1  PWM audio stream
- sample  output  SW  high-cycle count of the last window, range 0..WIN
- sample_valid  output  1  sample holds unconsumed data
- sample_ready  input  1  consumer accepts sample on this edge when valid is high
- overrun  output  1  sticky: a window result was dropped
- overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async): sync flops, win_cnt, hi_cnt, sample, sample_valid and overrun all go to 0 immediately. Asserting reset mid-window discards all state.
- Synchronizer: pwm_s is pwm_in delayed by SYNC_STAGES clocks.
- Counting, each posedge with en=1:
  - hi_cnt += pwm_s; win_cnt += 1.
  - When win_cnt == WIN-1 (the WIN-th counted cycle): result = hi_cnt + pwm_s, the "done" event fires, and win_cnt and hi_cnt return to 0.
- Each posedge with en=0:
  - win_cnt and hi_cnt are cleared; no done event fires.
  - The output buffer and overrun are untouched.
  - Re-enabling starts a fresh full window.
- Counter widths:
  - win_cnt is $clog2(WIN) bits and never exceeds WIN-1.
  - hi_cnt is SW bits and cannot overflow.
- Output buffer, priority per edge:
  - done and (!sample_valid or sample_ready): sample <= result; sample_valid <= 1.
  - done and sample_valid and !sample_ready: result dropped; sample unchanged; overrun <= 1.
  - No done, and sample_valid and sample_ready: sample_valid <= 0. sample keeps its last value.
- Latency: sample_valid rises on the same edge that counts the WIN-th bit, with no extra pipeline stage. Back-to-back windows produce one done every WIN clocks.
- Handshake rules:
  - sample is stable while sample_valid=1 and sample_ready=0.
  - sample_ready is ignored while sample_valid=0.
- Overrun:
  - overrun_clr=1 clears overrun on the next edge.
  - A simultaneous set and clear leaves overrun set; set wins.

Optional Feature:
- Macro: LOGS_PWM_AVG_EN.
- Defined:
  - A prev register (SW bits, reset 0) stores each window's raw result.
  - The delivered value is (result + prev + 1) >> 1, i.e. the two-window average with round-half-up, computed in SW+1 bits.
  - The first window after reset or after en=0 delivers the raw result; a first-window flag is cleared on each done.
  - prev and the flag are updated on every done, including dropped ones.
- Not defined: the raw result is delivered; prev and the flag are absent.

Test Plan:
- pwm_in=1 constant, en=1, sample_ready=1, defaults:
  - first sample_valid exactly 256 clocks after en is seen, with sample=256; pwm_in is asserted at least 2 clocks before en, so the first window counts only 1s;
  - then one pulse every 256 clocks, always 256.
- pwm_in=0 constant: every sample = 0; overrun stays 0.
- pwm_in with period 4, high 1 cycle: every sample = 64. Period 8 with 5 high: every sample = 160.
- sample_ready=0 across two window ends:
  - the first sample is held;
  - overrun=1 on the second done;
  - overrun_clr pulse clears it;
  - sample_ready=1 then drops sample_valid on the next edge.
- en dropped 100 cycles into a window, then raised: no sample from the partial window; the next sample arrives 256 clocks after re-enable. Async reset pulsed mid-window: all outputs 0 before the next clk edge.
- LOGS_PWM_AVG_EN defined, one window of all 1s then one window of all 0s: samples 256 then 128. Without the macro: samples 256 then 0.
